// File: rtl/fifo_read_arbiter.sv
// fifo_read_arbiter
//   Shares one FIFO read port between NUM_REQ burst requesters. An idle
//   arbiter grants the next pending requester in round-robin order, latches
//   that requester's burst length, issues that many FIFO reads (stalling
//   while the FIFO is empty), waits for every read to be acknowledged, and
//   then pulses done to the requester for one cycle before returning to idle.
//
// Ports
//   clk           single clock, rising edge
//   areset        asynchronous active-high reset
//   req           per-requester burst request (level)
//   req_len       packed burst lengths, requester i at [i*LEN_W +: LEN_W]
//   grant         registered one-hot grant
//   done          one-cycle burst-complete pulse to the granted requester
//   out_data      FIFO read data, forwarded combinationally
//   out_valid     per-requester data strobe
//   busy          arbiter not idle
//   fifo_rd_en    FIFO read strobe
//   fifo_rd_data  FIFO read data
//   fifo_rd_ack   FIFO read data valid (one or more cycles after fifo_rd_en)
//   fifo_empty    FIFO empty flag
module fifo_read_arbiter #(
    parameter int DATA_W  = 8,
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 8
) (
    input  logic                     clk,
    input  logic                     areset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic [DATA_W-1:0]        out_data,
    output logic [NUM_REQ-1:0]       out_valid,
    output logic                     busy,
    output logic                     fifo_rd_en,
    input  logic [DATA_W-1:0]        fifo_rd_data,
    input  logic                     fifo_rd_ack,
    input  logic                     fifo_empty
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t             state;
    logic [IDX_W-1:0]   last_grant;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   issued;
    logic [LEN_W-1:0]   acked;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_oh;
    logic [LEN_W-1:0]   pick_len;
    logic [31:0]        cand;
    logic [IDX_W-1:0]   cand_idx;

    logic               ack_take;
    logic [LEN_W-1:0]   acked_next;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        cand_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = 32'(last_grant) + 32'(k) + 32'd1;
            if (cand >= 32'(NUM_REQ)) begin
                cand = cand - 32'(NUM_REQ);
            end
            cand_idx = cand[IDX_W-1:0];
            if (!pick_found && req[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        pick_oh  = '0;
        pick_len = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_oh[i] = 1'b1;
                pick_len   = req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    // An ack only counts while a read is outstanding; stray acks (idle, or
    // left over from a burst abandoned by reset) are dropped here.
    assign ack_take   = fifo_rd_ack && (acked < issued);
    assign acked_next = acked + LEN_W'(ack_take);

    assign fifo_rd_en = (state == READ) && !fifo_empty && (issued < len_q);
    assign out_valid  = ack_take ? grant : '0;
    assign done       = (state == DONE) ? grant : '0;
    assign busy       = (state != IDLE);
    assign out_data   = fifo_rd_data;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
            len_q      <= '0;
            issued     <= '0;
            acked      <= '0;
        end else begin
            if (fifo_rd_en) begin
                issued <= issued + LEN_W'(1);
            end
            if (ack_take) begin
                acked <= acked_next;
            end
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state      <= READ;
                        grant      <= pick_oh;
                        last_grant <= pick_idx;
                        len_q      <= pick_len;
                        issued     <= '0;
                        acked      <= '0;
                    end
                end
                READ: begin
                    // A zero-length burst has nothing to drain.
                    if (issued == len_q) begin
                        state <= (len_q == '0) ? DONE : DRAIN;
                    end
                end
                DRAIN: begin
                    // Include an ack landing this cycle.
                    if (acked_next == len_q) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    grant <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_read_arbiter.sv
module tb_fifo_read_arbiter;

    logic        clk = 1'b0;
    logic        areset;
    logic [3:0]  req;
    logic [31:0] req_len;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic [7:0]  out_data;
    logic [3:0]  out_valid;
    logic        busy;
    logic        fifo_rd_en;
    logic [7:0]  fifo_rd_data = 8'h00;
    logic        fifo_rd_ack;
    logic        fifo_empty;

    // FIFO model: either acks each read one cycle later, or takes a
    // hand-driven ack.
    logic        auto_ack;
    logic        man_ack;
    logic        ack_pipe = 1'b0;
    logic [7:0]  data_src = 8'h40;

    int n_checks = 0;
    int n_fail   = 0;

    int         n_rd;
    int         n_ov[4];
    int         n_done[4];
    int         ov_at_done;
    logic [7:0] cap[8];
    int         ncap;
    logic [3:0] gr_order[8];
    int         ngr;
    logic [3:0] last_seen_grant;

    fifo_read_arbiter #(.DATA_W(8), .NUM_REQ(4), .LEN_W(8)) dut (
        .clk          (clk),
        .areset       (areset),
        .req          (req),
        .req_len      (req_len),
        .grant        (grant),
        .done         (done),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .busy         (busy),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_ack  (fifo_rd_ack),
        .fifo_empty   (fifo_empty)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ack_pipe <= fifo_rd_en;
        if (fifo_rd_en) begin
            fifo_rd_data <= data_src;
            data_src     <= data_src + 8'd1;
        end
    end

    assign fifo_rd_ack = auto_ack ? ack_pipe : man_ack;

    task automatic clear_counts();
        n_rd = 0;
        for (int i = 0; i < 4; i++) begin
            n_ov[i]   = 0;
            n_done[i] = 0;
        end
        ov_at_done      = 0;
        ncap            = 0;
        ngr             = 0;
        last_seen_grant = grant;
    endtask

    // One clock: observe at the falling edge, return just after the rising edge.
    task automatic cyc();
        @(negedge clk);
        if (fifo_rd_en) n_rd++;
        for (int i = 0; i < 4; i++) begin
            if (out_valid[i]) n_ov[i]++;
            if (done[i]) n_done[i]++;
        end
        if (done != 4'b0) ov_at_done = n_ov[0] + n_ov[1] + n_ov[2] + n_ov[3];
        if (out_valid != 4'b0 && ncap < 8) begin
            cap[ncap] = out_data;
            ncap++;
        end
        if (grant != 4'b0 && last_seen_grant == 4'b0 && ngr < 8) begin
            gr_order[ngr] = grant;
            ngr++;
        end
        last_seen_grant = grant;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        areset = 1'b1; req = 4'b0; req_len = 32'b0;
        fifo_empty = 1'b0; auto_ack = 1'b1; man_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (grant !== 4'b0) begin n_fail++; $display("FAIL rst_grant: got %0h expected 0", grant); end
        n_checks++; if (done !== 4'b0) begin n_fail++; $display("FAIL rst_done: got %0h expected 0", done); end
        n_checks++; if (out_valid !== 4'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0h expected 0", out_valid); end
        n_checks++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_rd_en: got %0b expected 0", fifo_rd_en); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b expected 0", busy); end
        areset = 1'b0;
        clear_counts();
        repeat (3) cyc();
        n_checks++; if (grant !== 4'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_hold: got grant %0h busy %0b expected 0 0", grant, busy); end
    endtask

    task automatic test_single_burst();
        int k;
        logic [7:0] base;
        base = data_src;
        clear_counts();
        req_len[7:0] = 8'd3;
        req = 4'b0001;
        k = 0;
        while (grant == 4'b0 && k < 10) begin cyc(); k++; end
        req = 4'b0;
        n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %0h expected 1", grant); end
        k = 0;
        while (n_done[0] == 0 && k < 30) begin cyc(); k++; end
        repeat (2) cyc();
        n_checks++; if (n_rd !== 3) begin n_fail++; $display("FAIL single_rd_en: got %0d expected 3", n_rd); end
        n_checks++; if (n_ov[0] !== 3) begin n_fail++; $display("FAIL single_out_valid: got %0d expected 3", n_ov[0]); end
        n_checks++; if (n_done[0] !== 1) begin n_fail++; $display("FAIL single_done: got %0d expected 1", n_done[0]); end
        n_checks++; if (grant !== 4'b0) begin n_fail++; $display("FAIL single_grant_clear: got %0h expected 0", grant); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (cap[i] !== base + 8'(i)) begin n_fail++; $display("FAIL single_data%0d: got %0h expected %0h", i, cap[i], base + 8'(i)); end
        end
    endtask

    task automatic test_round_robin();
        int k;
        logic [3:0] rr_exp[5];
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
        areset = 1'b1;
        @(posedge clk);
        #1;
        areset = 1'b0;
        clear_counts();
        req_len = {8'd1, 8'd1, 8'd1, 8'd1};
        req = 4'b1111;
        k = 0;
        while (ngr < 5 && k < 100) begin cyc(); k++; end
        req = 4'b0;
        repeat (8) cyc();
        n_checks++; if (ngr !== 5) begin n_fail++; $display("FAIL rr_grant_count: got %0d expected 5", ngr); end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (gr_order[i] !== rr_exp[i]) begin n_fail++; $display("FAIL rr_order%0d: got %0h expected %0h", i, gr_order[i], rr_exp[i]); end
        end
        n_checks++; if (n_done[0] !== 2) begin n_fail++; $display("FAIL rr_done0: got %0d expected 2", n_done[0]); end
    endtask

    task automatic test_empty_stall();
        int k;
        clear_counts();
        req_len[7:0] = 8'd4;
        req = 4'b0001;
        k = 0;
        while (grant == 4'b0 && k < 10) begin cyc(); k++; end
        req = 4'b0;
        n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL stall_grant: got %0h expected 1", grant); end
        k = 0;
        while (n_rd < 2 && k < 20) begin cyc(); k++; end
        fifo_empty = 1'b1;
        repeat (5) cyc();
        n_checks++; if (n_rd !== 2) begin n_fail++; $display("FAIL stall_rd_held: got %0d expected 2", n_rd); end
        n_checks++; if (busy !== 1'b1 || grant !== 4'b0001) begin n_fail++; $display("FAIL stall_busy: got busy %0b grant %0h expected 1 1", busy, grant); end
        fifo_empty = 1'b0;
        k = 0;
        while (n_done[0] == 0 && k < 30) begin cyc(); k++; end
        repeat (2) cyc();
        n_checks++; if (n_rd !== 4) begin n_fail++; $display("FAIL stall_rd_total: got %0d expected 4", n_rd); end
        n_checks++; if (ov_at_done !== 4) begin n_fail++; $display("FAIL stall_ack_before_done: got %0d expected 4", ov_at_done); end
        n_checks++; if (n_done[0] !== 1) begin n_fail++; $display("FAIL stall_done: got %0d expected 1", n_done[0]); end
    endtask

    task automatic test_zero_length();
        int k;
        clear_counts();
        req_len[23:16] = 8'd0;
        req = 4'b0100;
        k = 0;
        while (n_done[2] == 0 && k < 3) begin
            cyc();
            k++;
            if (grant != 4'b0) req = 4'b0;
        end
        n_checks++; if (n_done[2] !== 1) begin n_fail++; $display("FAIL zero_done_3cyc: got %0d expected 1", n_done[2]); end
        n_checks++; if (gr_order[0] !== 4'b0100) begin n_fail++; $display("FAIL zero_grant: got %0h expected 4", gr_order[0]); end
        req = 4'b0;
        repeat (3) cyc();
        n_checks++; if (n_rd !== 0) begin n_fail++; $display("FAIL zero_rd_en: got %0d expected 0", n_rd); end
        n_checks++; if (grant !== 4'b0 || n_done[2] !== 1) begin n_fail++; $display("FAIL zero_after: got grant %0h done %0d expected 0 1", grant, n_done[2]); end
    endtask

    task automatic test_reset_mid_burst();
        int k;
        clear_counts();
        auto_ack = 1'b0; man_ack = 1'b0;
        req_len[31:24] = 8'd5;
        req = 4'b1000;
        k = 0;
        while (grant == 4'b0 && k < 10) begin cyc(); k++; end
        req = 4'b0;
        n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL mid_grant: got %0h expected 8", grant); end
        k = 0;
        while (n_rd < 5 && k < 20) begin cyc(); k++; end
        cyc();
        n_checks++; if (busy !== 1'b1 || fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL mid_drain: got busy %0b rd_en %0b expected 1 0", busy, fifo_rd_en); end
        man_ack = 1'b1;
        #1;
        n_checks++; if (out_valid !== 4'b1000) begin n_fail++; $display("FAIL mid_ack_valid: got %0h expected 8", out_valid); end
        cyc();
        man_ack = 1'b0;
        areset = 1'b1;
        #1;
        n_checks++; if (grant !== 4'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_state: got grant %0h busy %0b expected 0 0", grant, busy); end
        n_checks++; if (done !== 4'b0 || out_valid !== 4'b0 || fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL mid_rst_outs: got done %0h ov %0h rd %0b expected 0 0 0", done, out_valid, fifo_rd_en); end
        repeat (2) cyc();
        areset = 1'b0;
        man_ack = 1'b1;
        repeat (2) cyc();
        man_ack = 1'b0;
        n_checks++; if (n_done[0] + n_done[1] + n_done[2] + n_done[3] !== 0) begin n_fail++; $display("FAIL mid_no_done: got %0d expected 0", n_done[3]); end
        n_checks++; if (n_ov[3] !== 1) begin n_fail++; $display("FAIL mid_late_ack: got %0d expected 1", n_ov[3]); end

        clear_counts();
        auto_ack = 1'b1;
        req_len[15:8] = 8'd2;
        req = 4'b0010;
        k = 0;
        while (grant == 4'b0 && k < 10) begin cyc(); k++; end
        req = 4'b0;
        n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL post_rst_grant: got %0h expected 2", grant); end
        k = 0;
        while (n_done[1] == 0 && k < 20) begin cyc(); k++; end
        repeat (2) cyc();
        n_checks++; if (n_rd !== 2 || n_ov[1] !== 2) begin n_fail++; $display("FAIL post_rst_burst: got rd %0d ov %0d expected 2 2", n_rd, n_ov[1]); end
        n_checks++; if (n_done[1] !== 1 || grant !== 4'b0) begin n_fail++; $display("FAIL post_rst_done: got done %0d grant %0h expected 1 0", n_done[1], grant); end
    endtask

    task automatic test_spurious_ack();
        int k;
        clear_counts();
        auto_ack = 1'b0;
        man_ack = 1'b1;
        repeat (3) cyc();
        man_ack = 1'b0;
        n_checks++; if (n_ov[0] + n_ov[1] + n_ov[2] + n_ov[3] !== 0) begin n_fail++; $display("FAIL spur_idle_valid: got %0d expected 0", n_ov[0] + n_ov[1] + n_ov[2] + n_ov[3]); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL spur_idle_busy: got %0b expected 0", busy); end
        fifo_empty = 1'b1;
        req_len[7:0] = 8'd2;
        req = 4'b0001;
        k = 0;
        while (grant == 4'b0 && k < 10) begin cyc(); k++; end
        req = 4'b0;
        man_ack = 1'b1;
        #1;
        n_checks++; if (out_valid !== 4'b0) begin n_fail++; $display("FAIL spur_read_valid: got %0h expected 0", out_valid); end
        cyc();
        man_ack = 1'b0;
        fifo_empty = 1'b0;
        auto_ack = 1'b1;
        k = 0;
        while (n_done[0] == 0 && k < 20) begin cyc(); k++; end
        repeat (2) cyc();
        n_checks++; if (n_ov[0] !== 2 || n_rd !== 2) begin n_fail++; $display("FAIL spur_burst: got ov %0d rd %0d expected 2 2", n_ov[0], n_rd); end
        n_checks++; if (n_done[0] !== 1) begin n_fail++; $display("FAIL spur_done: got %0d expected 1", n_done[0]); end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_empty_stall();
        test_zero_length();
        test_reset_mid_burst();
        test_spurious_ack();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fifo_read_arbiter.md
FIFO_READ_ARBITER -- requirements
Module: fifo_read_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, FIFO word width.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters.
REQ-003 SHALL have parameter LEN_W, default 8, burst-length field width.
REQ-004 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port areset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port req  in  NUM_REQ  per-requester burst request, level.
REQ-007 SHALL have port req_len  in  NUM_REQ*LEN_W  burst length; requester i uses bits [i*LEN_W +: LEN_W].
REQ-008 SHALL have port grant  out  NUM_REQ  one-hot grant, registered.
REQ-009 SHALL have port done  out  NUM_REQ  one-cycle burst-complete pulse to the granted requester.
REQ-010 SHALL have port out_data  out  DATA_W  fifo_rd_data forwarded combinationally.
REQ-011 SHALL have port out_valid  out  NUM_REQ  per-requester data strobe.
REQ-012 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-013 SHALL have port fifo_rd_en  out  1  FIFO read strobe.
REQ-014 SHALL have port fifo_rd_data  in  DATA_W  FIFO read data.
REQ-015 SHALL have port fifo_rd_ack  in  1  FIFO read-data-valid, one or more cycles after fifo_rd_en.
REQ-016 SHALL have port fifo_empty  in  1  FIFO empty flag, synchronous to clk.

Function
REQ-017 SHALL implement FSM states IDLE, READ, DRAIN, DONE.
REQ-018 IDLE: when any req bit is high, SHALL select the first requester with req high, searching round-robin from (last_grant+1) mod NUM_REQ, and SHALL latch its req_len into len_q. It SHALL then set grant one-hot, set last_grant, and move to READ.
REQ-019 IDLE with no req bit high SHALL hold; grant stays 0.
REQ-020 Zero-length request: when len_q==0, READ SHALL go directly to DONE without asserting fifo_rd_en.
REQ-021 READ: fifo_rd_en SHALL equal (!fifo_empty && issued<len_q); issued SHALL increment on each asserted fifo_rd_en.
REQ-022 READ SHALL go to DRAIN in the cycle after issued reaches len_q.
REQ-023 fifo_empty high in READ SHALL stall issuing without limit; no timeout.
REQ-024 Counting: acked SHALL increment on fifo_rd_ack only while acked<issued. An ack with no outstanding read SHALL be ignored and SHALL NOT assert out_valid.
REQ-025 out_valid[i] SHALL equal fifo_rd_ack && grant[i] && acked<issued.
REQ-026 DRAIN: when acked==len_q (including an ack arriving that cycle), the FSM SHALL go to DONE.
REQ-027 DONE SHALL last one cycle. done[g] SHALL be 1 for that cycle; grant SHALL clear on exit; the FSM SHALL return to IDLE.
REQ-028 issued and acked SHALL be LEN_W bits wide, cleared on entry to READ, and SHALL never wrap.
REQ-029 Deassertion of req mid-burst SHALL be ignored; the burst SHALL complete to len_q.
REQ-030 A requester still asserting req after done SHALL be re-arbitrated. Round-robin SHALL ensure every other pending requester is granted first.
REQ-031 Minimum gap between consecutive grants SHALL be one IDLE cycle.

Reset
REQ-032 areset high SHALL immediately force state IDLE and set grant, done, out_valid, fifo_rd_en, busy, issued, acked and len_q to 0.
REQ-033 areset SHALL set last_grant to NUM_REQ-1, so requester 0 has first priority.
REQ-034 Reset mid-burst SHALL abandon the burst with no done pulse. Acks arriving after reset release SHALL be ignored per REQ-024.

Verification
REQ-035 Single burst: req=4'b0001, len 3, FIFO non-empty, ack 1 cycle after rd_en -> 3 rd_en pulses, 3 out_valid[0] pulses, done[0] once, grant back to 0.
REQ-036 Round-robin: req=4'b1111 held, all len 1 -> grant order 0,1,2,3,0.
REQ-037 Empty stall: len 4 with fifo_empty high for 5 cycles after the 2nd read -> rd_en held low for those cycles, then 2 more reads; done after the 4th ack.
REQ-038 Zero length: req[2] with len 0 -> grant[2] set, no rd_en, done[2] pulses within 3 cycles.
REQ-039 Reset mid-burst: areset during DRAIN of a len-5 burst -> all outputs 0 in the same cycle, no done; after release, a new req[1] is served normally.
REQ-040 Spurious ack: fifo_rd_ack pulsed in IDLE -> no out_valid, no counter change.
